wb_write_sequencer: RTL and testbench
=====================================

Name: wb_write_sequencer

Overview:
- Sits between the MEM/WB pipeline register outputs and the single 32-bit register-file write port.
- Scalar results (ALU or load) are written in one beat.
- 128-bit matrix results are split into four 32-bit beats written to rd, rd+1, rd+2, rd+3.
- While a matrix burst drains, it asserts a stall to hold the pipeline.

Parameters:
- NBEATS, 4, number of 32-bit words per matrix result (word k = matrix_o[32k+31:32k]).
- XLEN, 32, register-file data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- wb_valid  input  1  the wb_* inputs carry a retiring instruction this cycle.
- wb_rd  input  5  destination register (base register for matrix).
- wb_mem2reg  input  1  scalar source select: 1 = wb_mem_data, 0 = wb_alu_o.
- wb_w_select  input  2  00 = no write, 01 = scalar write, 10 = matrix write, 11 = reserved (no write).
- wb_mem_data  input  32  load data.
- wb_alu_o  input  32  ALU result.
- wb_matrix_o  input  128  matrix result.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  5  register-file write address.
- rf_wdata  output  32  register-file write data.
- wb_stall  output  1  hold the MEM/WB register and all upstream stages.
- busy  output  1  matrix burst in progress (equals state==BURST).

Behaviour:
- Reset: asynchronous, active-low, applies mid-operation. Forces state=IDLE, beat count=0, rf_we=0, rf_waddr=0, rf_wdata=0, wb_stall=0, busy=0. Any partially written matrix is abandoned; the words already written stay written.
- rf_we, rf_waddr and rf_wdata are registered: a write appears one cycle after acceptance.
- Accept condition: wb_valid && !wb_stall. Inputs arriving while wb_stall=1 are not sampled; upstream must hold them stable.
- wb_stall = busy (combinational from state).
- IDLE state:
  - Accept with w_select=01: next cycle rf_we=1, rf_waddr=wb_rd, rf_wdata = mem2reg ? mem_data : alu_o. Stay in IDLE.
  - Accept with w_select=10:
    - Capture wb_matrix_o and wb_rd into internal buffers.
    - Next cycle: rf_we=1, rf_waddr=rd, rf_wdata=word0.
    - Go to BURST with count=1.
  - Accept with w_select=00 or 11, or no accept: next cycle rf_we=0. rf_waddr and rf_wdata hold their previous values.
- BURST state: on each edge emit rf_waddr = (rd+count) mod 32 and rf_wdata = word[count], then count++.
  - When the emitted beat is count=NBEATS-1, return to IDLE.
  - Stall is high for exactly NBEATS-1 = 3 cycles.
  - The first post-burst accept can occur on the cycle busy falls, so its write follows word3 with no gap.
- x0 rule: any beat whose address is 0 drives rf_we=0. The beat still consumes its cycle; address and data are driven as normal.
- Register wrap: rd+k is computed mod 32. Example: rd=30 writes 30, 31, 0 (suppressed), 1.
- Captured buffers are immune to input changes during BURST.
- Throughput: one scalar per cycle; one matrix per 4 cycles.

Test Plan:
- Scalar back-to-back: two accepts, (rd=5, mem2reg=0, alu_o=0x11111111) then (rd=6, mem2reg=1, mem_data=0x22222222) -> rf_we=1 on the next two cycles writing x5=0x11111111, x6=0x22222222; wb_stall stays 0.
- Matrix burst: rd=8, matrix=0x44444444_33333333_22222222_11111111 -> four consecutive writes x8=0x11111111, x9=0x22222222, x10=0x33333333, x11=0x44444444; wb_stall=1 for 3 cycles. Inputs changed during the stall are ignored.
- Wrap and x0: matrix with rd=30 -> addresses 30, 31, 0, 1; rf_we pattern 1, 1, 0, 1.
- Scalar to x0 and w_select=11 with wb_valid=1 -> rf_we stays 0, no stall.
- Reset mid-burst: rst low after the beat-1 write -> rf_we, wb_stall and busy go 0 immediately (asynchronous). After release, a scalar rd=3, alu_o=0xA5A5A5A5 writes correctly with no leftover beats.
- Matrix followed immediately by scalar held on the inputs: scalar write occurs in the cycle right after word3, with no gap and no duplicate write.

Source files
------------

// File: rtl/wb_write_sequencer.sv
// ============================================================================
//  Module   : wb_write_sequencer
//  Purpose  : Drives the single register-file write port from MEM/WB; scalar
//             results in one beat, matrix results as NBEATS consecutive beats.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_write_sequencer #(
  parameter int NBEATS = 4,
  parameter int XLEN   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic                     wb_mem2reg,
  input  logic [1:0]               wb_w_select,
  input  logic [XLEN-1:0]          wb_mem_data,
  input  logic [XLEN-1:0]          wb_alu_o,
  input  logic [NBEATS*XLEN-1:0]   wb_matrix_o,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic                     wb_stall,
  output logic                     busy
);

  localparam int         c_CW         = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [1:0] c_SEL_SCALAR = 2'b01;
  localparam logic [1:0] c_SEL_MATRIX = 2'b10;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                   r_state;
  logic [c_CW-1:0]          r_count;
  logic [4:0]               r_rd;
  logic [NBEATS*XLEN-1:0]   r_buf;

  logic                     w_accept;
  logic [4:0]               w_beat_addr;
  logic [XLEN-1:0]          w_scalar;
  logic [XLEN-1:0]          w_words [NBEATS];

  genvar k;
  generate
    for (k = 0; k < NBEATS; k++) begin : g_words
      assign w_words[k] = r_buf[k*XLEN +: XLEN];
    end
  endgenerate

  assign busy        = (r_state == BURST);
  assign wb_stall    = busy;
  assign w_accept    = wb_valid && !wb_stall;
  // Register numbers wrap naturally in the 5-bit sum.
  assign w_beat_addr = r_rd + 5'(r_count);
  assign w_scalar    = wb_mem2reg ? wb_mem_data : wb_alu_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_rd     <= '0;
      r_buf    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && wb_w_select == c_SEL_SCALAR) begin
            rf_we    <= (wb_rd != 5'd0);
            rf_waddr <= wb_rd;
            rf_wdata <= w_scalar;
          end else if (w_accept && wb_w_select == c_SEL_MATRIX) begin
            r_buf    <= wb_matrix_o;
            r_rd     <= wb_rd;
            rf_we    <= (wb_rd != 5'd0);
            rf_waddr <= wb_rd;
            rf_wdata <= wb_matrix_o[XLEN-1:0];
            r_count  <= c_CW'(1);
            r_state  <= (NBEATS > 1) ? BURST : IDLE;
          end else begin
            rf_we <= 1'b0;
          end
        end
        BURST: begin
          rf_we    <= (w_beat_addr != 5'd0);
          rf_waddr <= w_beat_addr;
          rf_wdata <= w_words[r_count];
          if (r_count == c_CW'(NBEATS-1)) begin
            r_count <= '0;
            r_state <= IDLE;
          end else begin
            r_count <= r_count + c_CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
          rf_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_write_sequencer.sv
// ============================================================================
//  Module   : tb_wb_write_sequencer
//  Purpose  : Directed self-checking bench for wb_write_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_write_sequencer;

  logic         clk;
  logic         rst;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic         wb_mem2reg;
  logic [1:0]   wb_w_select;
  logic [31:0]  wb_mem_data;
  logic [31:0]  wb_alu_o;
  logic [127:0] wb_matrix_o;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic         wb_stall;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  wb_write_sequencer #(.NBEATS(4), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_mem2reg  (wb_mem2reg),
    .wb_w_select (wb_w_select),
    .wb_mem_data (wb_mem_data),
    .wb_alu_o    (wb_alu_o),
    .wb_matrix_o (wb_matrix_o),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .wb_stall    (wb_stall),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] addr,
                        input logic [31:0] data, input logic stall);
    chk({tag, ".we"},    32'(rf_we),    32'(we));
    chk({tag, ".addr"},  32'(rf_waddr), 32'(addr));
    chk({tag, ".data"},  rf_wdata,      data);
    chk({tag, ".stall"}, 32'(wb_stall), 32'(stall));
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [4:0] rd,
                       input logic m2r, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [127:0] mat);
    wb_valid    = v;
    wb_w_select = sel;
    wb_rd       = rd;
    wb_mem2reg  = m2r;
    wb_alu_o    = alu;
    wb_mem_data = mem;
    wb_matrix_o = mat;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 128'h0);
    repeat (3) step();
    chk_wr("reset", 1'b0, 5'd0, 32'h0, 1'b0);
    chk("reset.busy", 32'(busy), 32'h0);
    rst = 1'b1;

    // Scalar back-to-back
    drive(1'b1, 2'b01, 5'd5, 1'b0, 32'h11111111, 32'hDEADBEEF, 128'h0);
    step();
    chk_wr("sc0", 1'b1, 5'd5, 32'h11111111, 1'b0);
    drive(1'b1, 2'b01, 5'd6, 1'b1, 32'hCAFEF00D, 32'h22222222, 128'h0);
    step();
    chk_wr("sc1", 1'b1, 5'd6, 32'h22222222, 1'b0);
    drive(1'b0, 2'b01, 5'd9, 1'b0, 32'h99999999, 32'h0, 128'h0);
    step();
    chk_wr("sc_idle", 1'b0, 5'd6, 32'h22222222, 1'b0);

    // Matrix burst, inputs disturbed while stalled
    drive(1'b1, 2'b10, 5'd8, 1'b0, 32'h0, 32'h0,
          128'h44444444_33333333_22222222_11111111);
    step();
    chk_wr("mx0", 1'b1, 5'd8, 32'h11111111, 1'b1);
    chk("mx0.busy", 32'(busy), 32'h1);
    drive(1'b1, 2'b10, 5'd20, 1'b1, 32'h77777777, 32'h88888888,
          128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    step();
    chk_wr("mx1", 1'b1, 5'd9, 32'h22222222, 1'b1);
    step();
    chk_wr("mx2", 1'b1, 5'd10, 32'h33333333, 1'b1);
    step();
    chk_wr("mx3", 1'b1, 5'd11, 32'h44444444, 1'b0);
    chk("mx3.busy", 32'(busy), 32'h0);
    drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 128'h0);
    step();
    chk_wr("mx_end", 1'b0, 5'd11, 32'h44444444, 1'b0);

    // Wrap through x0
    drive(1'b1, 2'b10, 5'd30, 1'b0, 32'h0, 32'h0,
          128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
    step();
    chk_wr("wr0", 1'b1, 5'd30, 32'hA0A0A0A0, 1'b1);
    drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 128'h0);
    step();
    chk_wr("wr1", 1'b1, 5'd31, 32'hA1A1A1A1, 1'b1);
    step();
    chk_wr("wr2", 1'b0, 5'd0, 32'hA2A2A2A2, 1'b1);
    step();
    chk_wr("wr3", 1'b1, 5'd1, 32'hA3A3A3A3, 1'b0);

    // Scalar to x0, then reserved select
    drive(1'b1, 2'b01, 5'd0, 1'b0, 32'h12345678, 32'h0, 128'h0);
    step();
    chk_wr("x0", 1'b0, 5'd0, 32'h12345678, 1'b0);
    drive(1'b1, 2'b11, 5'd7, 1'b0, 32'h87654321, 32'h0, 128'hFFFF);
    step();
    chk_wr("sel11", 1'b0, 5'd0, 32'h12345678, 1'b0);
    chk("sel11.busy", 32'(busy), 32'h0);

    // Asynchronous reset mid-burst
    drive(1'b1, 2'b10, 5'd12, 1'b0, 32'h0, 32'h0,
          128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
    step();
    chk_wr("rb0", 1'b1, 5'd12, 32'hB0B0B0B0, 1'b1);
    drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 128'h0);
    step();
    chk_wr("rb1", 1'b1, 5'd13, 32'hB1B1B1B1, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_wr("rb_rst", 1'b0, 5'd0, 32'h0, 1'b0);
    chk("rb_rst.busy", 32'(busy), 32'h0);
    step();
    step();
    rst = 1'b1;
    drive(1'b1, 2'b01, 5'd3, 1'b0, 32'hA5A5A5A5, 32'h0, 128'h0);
    step();
    chk_wr("post_rst", 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0);
    drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 128'h0);
    step();
    chk_wr("post_rst_idle", 1'b0, 5'd3, 32'hA5A5A5A5, 1'b0);

    // Matrix followed by a scalar held on the inputs
    drive(1'b1, 2'b10, 5'd16, 1'b0, 32'h0, 32'h0,
          128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0);
    step();
    chk_wr("ms0", 1'b1, 5'd16, 32'hC0C0C0C0, 1'b1);
    drive(1'b1, 2'b01, 5'd2, 1'b0, 32'h5C5C5C5C, 32'h0, 128'h0);
    step();
    chk_wr("ms1", 1'b1, 5'd17, 32'hC1C1C1C1, 1'b1);
    step();
    chk_wr("ms2", 1'b1, 5'd18, 32'hC2C2C2C2, 1'b1);
    step();
    chk_wr("ms3", 1'b1, 5'd19, 32'hC3C3C3C3, 1'b0);
    step();
    chk_wr("ms_sc", 1'b1, 5'd2, 32'h5C5C5C5C, 1'b0);
    drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 128'h0);
    step();
    chk_wr("ms_end", 1'b0, 5'd2, 32'h5C5C5C5C, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
